// File: rtl/fifo_ch_ctrl.sv
// Flow-control sequencer for a fixed-latency multi-channel delay line: shadows
// per-stage valid/last flags, drives shift-enable/sync-clear and sequences flush.
module fifo_ch_ctrl #(
    parameter int FIFO_LEN  = 4,
    parameter int OCC_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 in_ctr_Arst_n,
    input  logic                 in_ctr_Srst,
    input  logic                 in_flush,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic                 out_ready,
    output logic                 in_ready,
    output logic                 ctr_fifo_en,
    output logic                 ctr_fifo_Srst,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [OCC_WIDTH-1:0] out_occ,
    output logic [OCC_WIDTH-1:0] out_cw_cnt,
    output logic [1:0]           out_state,
    output logic                 out_flush_done
);

    // Handshake: upstream transfer when in_valid & in_ready; downstream transfer
    // when out_valid & out_ready. A full tail without out_ready stalls every stage.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [FIFO_LEN-1:0]   vld_q, vld_d;
    logic [FIFO_LEN-1:0]   lst_q, lst_d;
    logic [OCC_WIDTH-1:0]  occ_q, occ_d;
    logic [OCC_WIDTH-1:0]  cw_q, cw_d;
    logic                  done_q, done_d;
    logic                  en;
    logic                  accept;

    function automatic logic [OCC_WIDTH-1:0] popcnt(input logic [FIFO_LEN-1:0] v);
        logic [OCC_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < FIFO_LEN; i++) begin
            c = c + OCC_WIDTH'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        en     = (state_q != S_CLEAR) && !in_ctr_Srst && (!vld_q[FIFO_LEN-1] || out_ready);
        accept = in_valid && en && ((state_q == S_IDLE) || (state_q == S_RUN));
    end

    always_comb begin
        vld_d   = vld_q;
        lst_d   = lst_q;
        state_d = state_q;
        done_d  = 1'b0;

        if (en) begin
            vld_d[0] = accept;
            lst_d[0] = accept && in_last;
            for (int i = 1; i < FIFO_LEN; i++) begin
                vld_d[i] = vld_q[i-1];
                lst_d[i] = lst_q[i-1];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_flush)    state_d = S_FLUSH;
                else if (accept) state_d = S_RUN;
            end
            S_RUN: begin
                if (in_flush)            state_d = S_FLUSH;
                else if (vld_d == '0)    state_d = S_IDLE;
            end
            S_FLUSH: begin
                // Post-edge emptiness means the last word has been taken downstream.
                if (vld_d == '0) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                vld_d   = '0;
                lst_d   = '0;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Sync clear outranks flush and data, and never reports a completed flush.
        if (in_ctr_Srst) begin
            vld_d   = '0;
            lst_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b0;
        end

        occ_d = popcnt(vld_d);
        cw_d  = popcnt(lst_d);
    end

    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            state_q <= S_IDLE;
            vld_q   <= '0;
            lst_q   <= '0;
            occ_q   <= '0;
            cw_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            lst_q   <= lst_d;
            occ_q   <= occ_d;
            cw_q    <= cw_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        ctr_fifo_en    = en;
        in_ready       = en && ((state_q == S_IDLE) || (state_q == S_RUN));
        ctr_fifo_Srst  = in_ctr_Srst || (state_q == S_CLEAR);
        out_valid      = vld_q[FIFO_LEN-1];
        out_last       = lst_q[FIFO_LEN-1];
        out_occ        = occ_q;
        out_cw_cnt     = cw_q;
        out_state      = state_q;
        out_flush_done = done_q;
    end

endmodule

// File: tb/tb_fifo_ch_ctrl.sv
// Bench for fifo_ch_ctrl: directed scenarios plus random traffic against a
// word-age queue model of the delay line.
module tb_fifo_ch_ctrl;

    localparam int L = 4;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         srst = 1'b0;
    logic         flush = 1'b0;
    logic         iv = 1'b0;
    logic         il = 1'b0;
    logic         ordy = 1'b0;
    logic         in_ready, ctr_fifo_en, ctr_fifo_Srst, out_valid, out_last, out_flush_done;
    logic [W-1:0] out_occ, out_cw_cnt;
    logic [1:0]   out_state;

    int checks = 0;
    int errors = 0;

    // Model: each word in flight carries its age in enabled edges (tail at age L).
    int         m_age[$];
    logic [0:0] exp_q[$];
    int         m_state = 0;
    logic       m_done = 1'b0;

    logic s_in_ready, s_en, s_srst;
    logic p_in_ready, p_en, p_srst;

    fifo_ch_ctrl #(.FIFO_LEN(L), .OCC_WIDTH(W)) dut (
        .clk(clk), .in_ctr_Arst_n(rst_n), .in_ctr_Srst(srst), .in_flush(flush),
        .in_valid(iv), .in_last(il), .out_ready(ordy), .in_ready(in_ready),
        .ctr_fifo_en(ctr_fifo_en), .ctr_fifo_Srst(ctr_fifo_Srst), .out_valid(out_valid),
        .out_last(out_last), .out_occ(out_occ), .out_cw_cnt(out_cw_cnt),
        .out_state(out_state), .out_flush_done(out_flush_done)
    );

    always #5 clk = ~clk;

    function automatic bit m_tailv();
        return (m_age.size() > 0) && (m_age[0] == L);
    endfunction

    function automatic int m_cw();
        int c = 0;
        foreach (exp_q[i]) if (exp_q[i] == 1'b1) c++;
        return c;
    endfunction

    function automatic logic m_last();
        return m_tailv() ? exp_q[0][0] : 1'b0;
    endfunction

    task automatic model_reset();
        m_age.delete();
        exp_q.delete();
        m_state = 0;
        m_done  = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic l, input logic r, input logic f, input logic s);
        bit en_, acc_;
        en_  = !s && (m_state != 3) && (!m_tailv() || r);
        acc_ = v && en_ && (m_state <= 1);
        if (s) begin
            model_reset();
        end else if (m_state == 3) begin
            m_age.delete();
            exp_q.delete();
            m_state = 0;
            m_done  = 1'b1;
        end else begin
            m_done = 1'b0;
            if (en_) begin
                if (m_tailv()) begin
                    void'(m_age.pop_front());
                    void'(exp_q.pop_front());
                end
                foreach (m_age[i]) m_age[i]++;
                if (acc_) begin
                    m_age.push_back(1);
                    exp_q.push_back(l);
                end
            end
            case (m_state)
                0: if (f) m_state = 2; else if (acc_) m_state = 1;
                1: if (f) m_state = 2; else if (m_age.size() == 0) m_state = 0;
                2: if (m_age.size() == 0) m_state = 3;
                default: m_state = 0;
            endcase
        end
    endtask

    // Inputs applied 1 time unit after the rising edge; combinational outputs
    // captured on the falling edge; registered outputs valid 1 unit after return.
    task automatic drive_cycle(input logic v, input logic l, input logic r, input logic f, input logic s);
        iv = v; il = l; ordy = r; flush = f; srst = s;
        @(negedge clk);
        s_in_ready = in_ready;
        s_en       = ctr_fifo_en;
        s_srst     = ctr_fifo_Srst;
        p_en       = !s && (m_state != 3) && (!m_tailv() || r);
        p_in_ready = p_en && (m_state <= 1);
        p_srst     = s || (m_state == 3);
        @(posedge clk);
        model_edge(v, l, r, f, s);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_occ !== '0 || out_cw_cnt !== '0 ||
            out_state !== 2'd0 || out_flush_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b last=%b occ=%0d cw=%0d state=%0d done=%b required all 0",
                     out_valid, out_last, out_occ, out_cw_cnt, out_state, out_flush_done);
        end
        rst_n = 1'b1;
        model_reset();
        drive_cycle(0, 0, 1, 0, 0);
        checks++;
        if (s_en !== 1'b1 || s_in_ready !== 1'b1 || s_srst !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_ctrl: en=%b in_ready=%b srst=%b required 1 1 0", s_en, s_in_ready, s_srst);
        end
    endtask

    task automatic test_latency();
        for (int k = 0; k < 6; k++) begin
            int   e_occ;
            logic e_ov;
            if (k == 0) drive_cycle(1, 1, 1, 0, 0);
            else        drive_cycle(0, 0, 1, 0, 0);
            e_occ = (k < 4) ? 1 : 0;
            e_ov  = (k == 3);
            checks++;
            if (out_occ !== W'(e_occ) || out_cw_cnt !== W'(e_occ) || out_valid !== e_ov || out_last !== e_ov) begin
                errors++;
                $display("FAIL latency_c%0d: occ=%0d cw=%0d valid=%b last=%b required %0d %0d %b %b",
                         k + 1, out_occ, out_cw_cnt, out_valid, out_last, e_occ, e_occ, e_ov, e_ov);
            end
        end
        drive_cycle(0, 1, 1, 0, 0);
        checks++;
        if (out_cw_cnt !== '0 || out_occ !== '0 || out_state !== 2'd0) begin
            errors++;
            $display("FAIL last_without_valid: cw=%0d occ=%0d state=%0d required 0 0 0", out_cw_cnt, out_occ, out_state);
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 6; c++) drive_cycle(1, 0, (c < 5), 0, 0);
        checks++;
        if (out_occ !== W'(4) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_full: occ=%0d valid=%b required 4 1", out_occ, out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1, 0, 0, 0, 0);
            checks++;
            if (s_in_ready !== 1'b0 || s_en !== 1'b0 || out_occ !== W'(4)) begin
                errors++;
                $display("FAIL stall_hold: in_ready=%b en=%b occ=%0d required 0 0 4", s_in_ready, s_en, out_occ);
            end
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_valid !== 1'b1 || out_occ !== W'(4 - j)) begin
                errors++;
                $display("FAIL stall_release_%0d: valid=%b occ=%0d required 1 %0d", j, out_valid, out_occ, 4 - j);
            end
            drive_cycle(0, 0, 1, 0, 0);
        end
        checks++;
        if (out_valid !== 1'b0 || out_occ !== '0 || out_state !== 2'd0) begin
            errors++;
            $display("FAIL stall_drained: valid=%b occ=%0d state=%0d required 0 0 0", out_valid, out_occ, out_state);
        end
    endtask

    task automatic test_flush();
        logic [2:0] pat;
        int xfers, srst_seen, done_cnt, cyc;
        pat = 3'b010;
        for (int i = 0; i < 3; i++) drive_cycle(1, pat[i], 1, 0, 0);
        xfers = 0; srst_seen = 0; done_cnt = 0; cyc = 0;
        drive_cycle(0, 0, 1, 1, 0);
        while (done_cnt == 0 && cyc < 20) begin
            logic st2, ov, ol;
            st2 = (out_state == 2'd2);
            ov  = out_valid;
            ol  = out_last;
            drive_cycle(1, 0, 1, 0, 0);
            if (st2) begin
                checks++;
                if (s_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_in_ready: in_ready=%b required 0", s_in_ready);
                end
            end
            if (ov) begin
                checks++;
                if (xfers > 2 || ol !== pat[xfers]) begin
                    errors++;
                    $display("FAIL flush_order_%0d: last=%b required %b", xfers, ol, (xfers > 2) ? 1'b0 : pat[xfers]);
                end
                xfers++;
            end
            if (s_srst) srst_seen++;
            if (out_flush_done) done_cnt++;
            cyc++;
        end
        checks++;
        if (xfers != 3 || srst_seen != 1 || done_cnt != 1 || out_state !== 2'd0 || out_occ !== '0) begin
            errors++;
            $display("FAIL flush_complete: xfers=%0d srst_cycles=%0d done=%0d state=%0d occ=%0d required 3 1 1 0 0",
                     xfers, srst_seen, done_cnt, out_state, out_occ);
        end
        drive_cycle(0, 0, 1, 0, 0);
        checks++;
        if (out_flush_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_single_pulse: done=%b required 0", out_flush_done);
        end
        drive_cycle(0, 0, 1, 1, 0);
        checks++;
        if (out_state !== 2'd2) begin
            errors++;
            $display("FAIL empty_flush_s1: state=%0d required 2", out_state);
        end
        drive_cycle(0, 0, 1, 0, 0);
        checks++;
        if (out_state !== 2'd3 || out_occ !== '0) begin
            errors++;
            $display("FAIL empty_flush_s2: state=%0d occ=%0d required 3 0", out_state, out_occ);
        end
        drive_cycle(0, 0, 1, 0, 0);
        checks++;
        if (out_state !== 2'd0 || out_flush_done !== 1'b1 || s_srst !== 1'b1) begin
            errors++;
            $display("FAIL empty_flush_s3: state=%0d done=%b srst=%b required 0 1 1", out_state, out_flush_done, s_srst);
        end
    endtask

    task automatic test_srst();
        for (int i = 0; i < 4; i++) drive_cycle(1, (i == 1), 0, 0, 0);
        checks++;
        if (out_occ !== W'(4) || out_cw_cnt !== W'(1)) begin
            errors++;
            $display("FAIL srst_fill: occ=%0d cw=%0d required 4 1", out_occ, out_cw_cnt);
        end
        drive_cycle(1, 0, 0, 1, 1);
        checks++;
        if (s_srst !== 1'b1 || s_en !== 1'b0 || s_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL srst_comb: srst=%b en=%b in_ready=%b required 1 0 0", s_srst, s_en, s_in_ready);
        end
        checks++;
        if (out_occ !== '0 || out_cw_cnt !== '0 || out_valid !== 1'b0 || out_state !== 2'd0 || out_flush_done !== 1'b0) begin
            errors++;
            $display("FAIL srst_after: occ=%0d cw=%0d valid=%b state=%0d done=%b required 0 0 0 0 0",
                     out_occ, out_cw_cnt, out_valid, out_state, out_flush_done);
        end
        drive_cycle(0, 0, 1, 0, 0);
        checks++;
        if (out_flush_done !== 1'b0 || out_state !== 2'd0) begin
            errors++;
            $display("FAIL srst_no_done: done=%b state=%0d required 0 0", out_flush_done, out_state);
        end
    endtask

    task automatic test_stream();
        for (int n = 0; n < 24; n++) begin
            int e_cw;
            drive_cycle(1, (n % 3 == 0), 1, 0, 0);
            if (n >= 3) begin
                e_cw = 0;
                for (int j = n - 3; j <= n; j++) if (j % 3 == 0) e_cw++;
                checks++;
                if (out_occ !== W'(4) || out_cw_cnt !== W'(e_cw) || out_last !== ((n - 3) % 3 == 0) || s_in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_%0d: occ=%0d cw=%0d last=%b in_ready=%b required 4 %0d %b 1",
                             n, out_occ, out_cw_cnt, out_last, s_in_ready, e_cw, ((n - 3) % 3 == 0));
                end
            end
        end
        for (int i = 0; i < 5; i++) drive_cycle(0, 0, 1, 0, 0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1, 1, 0, 0, 0);
        drive_cycle(0, 0, 0, 1, 0);
        drive_cycle(0, 0, 0, 0, 0);
        checks++;
        if (out_state !== 2'd2) begin
            errors++;
            $display("FAIL async_in_flush: state=%0d required 2", out_state);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_occ !== '0 || out_cw_cnt !== '0 ||
            out_state !== 2'd0 || out_flush_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b last=%b occ=%0d cw=%0d state=%0d done=%b required all 0",
                     out_valid, out_last, out_occ, out_cw_cnt, out_state, out_flush_done);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive_cycle(1, 1, 1, 0, 0);
            else        drive_cycle(0, 0, 1, 0, 0);
            checks++;
            if (out_valid !== (k == 3) || out_flush_done !== 1'b0) begin
                errors++;
                $display("FAIL async_resume_%0d: valid=%b done=%b required %b 0", k, out_valid, out_flush_done, (k == 3));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            logic v, l, r, f, s;
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 79) == 0);
            drive_cycle(v, l, r, f, s);
            checks++;
            if (s_in_ready !== p_in_ready || s_en !== p_en || s_srst !== p_srst) begin
                errors++;
                $display("FAIL random_comb_%0d: in_ready=%b en=%b srst=%b required %b %b %b",
                         n, s_in_ready, s_en, s_srst, p_in_ready, p_en, p_srst);
            end
            checks++;
            if (out_valid !== m_tailv() || out_last !== m_last() || out_occ !== W'(m_age.size()) ||
                out_cw_cnt !== W'(m_cw()) || out_state !== 2'(m_state) || out_flush_done !== m_done) begin
                errors++;
                $display("FAIL random_reg_%0d: valid=%b last=%b occ=%0d cw=%0d state=%0d done=%b required %b %b %0d %0d %0d %b",
                         n, out_valid, out_last, out_occ, out_cw_cnt, out_state, out_flush_done,
                         m_tailv(), m_last(), m_age.size(), m_cw(), m_state, m_done);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_latency();
        test_stall();
        test_flush();
        test_srst();
        test_stream();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
